rggen_bit_field_rwlk: RTL and testbench
=======================================

# rggen_bit_field_rwlk

Multi-channel lockable read-write bit field with an internal two-key unlock sequencer. It generalises the single-lock RWL field in two ways: it holds CHANNELS independent WIDTH-bit fields, and a key handshake FSM generates the lock internally. An optional auto-relock timer returns the field to LOCKED after a period of inactivity. It sits between the register block's bit-field bus and the fabric logic that consumes the field values.

## Interface
- WIDTH, 8, bits per channel; also the key width.
- CHANNELS, 2, number of independent fields (≥1).
- INITIAL_VALUE, {CHANNELS*WIDTH{1'b0}}, reset value; channel c occupies bits [c*WIDTH +: WIDTH].
- KEY0, 8'hA5 (WIDTH bits), first unlock key.
- KEY1, 8'h5A (WIDTH bits), second unlock key.
- TIMEOUT, 16, auto-relock idle cycles (≥1); used only with RGGEN_RWLK_TIMEOUT_EN.
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_bit_field_valid  input  1  bus access strobe.
- i_bit_field_read_mask  input  CHANNELS*WIDTH  read mask (accepted, unused).
- i_bit_field_write_mask  input  CHANNELS*WIDTH  per-bit write enable.
- i_bit_field_write_data  input  CHANNELS*WIDTH  write data.
- o_bit_field_read_data  output  CHANNELS*WIDTH  current field values.
- o_bit_field_value  output  CHANNELS*WIDTH  current field values.
- i_key_valid  input  1  key write strobe.
- i_key_data  input  WIDTH  key value.
- i_lock  input  1  force-lock; highest priority.
- o_locked  output  1  1 unless the state is OPEN.
- o_state  output  2  LOCKED=0, ARMED=1, OPEN=2.
- o_value  output  CHANNELS*WIDTH  current field values.

## Operation
- Reset (i_rst=1 at an edge): values=INITIAL_VALUE, state=LOCKED, timer=0, o_locked=1, o_state=0.
- Transitions are evaluated in this priority order:
  - i_lock=1: next state LOCKED from any state.
  - LOCKED: i_key_valid with data==KEY0 → ARMED; otherwise stay.
  - ARMED: i_key_valid with data==KEY1 → OPEN; i_key_valid with any other value → LOCKED; no key → stay.
  - OPEN: any i_key_valid → LOCKED (explicit relock); timer expiry → LOCKED; otherwise stay.
- Write acceptance: i_bit_field_valid && |write_mask && state==OPEN && !i_lock.
  - The check uses the current (pre-edge) state.
  - An accepted write sets new = (data & mask) | (value & ~mask) across all channels at once.
  - Rejected writes leave every value unchanged.
- A simultaneous key write and field write in OPEN: the field write is accepted, and the state becomes LOCKED on the next cycle.
- KEY0==KEY1 is legal; the same value must then be written twice in sequence.

## Timing
- Write latency: a write accepted in cycle m is visible on all value outputs in cycle m+1.
- Unlock: KEY0 in cycle n, KEY1 in cycle k>n (no intervening key) → o_locked=0 from cycle k+1. The earliest accepted write is in cycle k+1.
- o_locked and o_state are registered-state decodes with no combinational path from inputs.
- Timer (when compiled in):
  - Loaded with TIMEOUT on the edge entering OPEN and on every accepted write.
  - Decrements each OPEN cycle with no accepted write.
  - When it reads 1 with no write, the next state is LOCKED.
  - Net effect: OPEN lasts exactly TIMEOUT cycles after entry or after the last accepted write.
- Timer width is $clog2(TIMEOUT+1). The timer is cleared whenever the state is not OPEN.
- Reset asserted mid-sequence (ARMED or OPEN) returns the block to the reset state on that edge. A same-cycle write is dropped.

## Configuration
- Macro: RGGEN_RWLK_TIMEOUT_EN.
- Defined: the auto-relock timer is present as described in Timing.
- Undefined: no timer logic; TIMEOUT is ignored. OPEN persists until i_lock, a key write, or reset.

## Test plan
- Reset then full write (mask all 1s, data 16'hFFFF, CHANNELS=2, WIDTH=8) → value stays 16'h0000 and o_state=0.
- KEY0=A5 then KEY1=5A on consecutive cycles, then write data 16'h1234 with mask 16'h00FF in the next cycle → o_locked=0 and value 16'h0034 one cycle later.
- Wrong sequences: KEY0 then 8'h00 → state LOCKED. Retrying KEY1 alone → stays LOCKED, and writes are ignored.
- OPEN, then i_lock=1 in the same cycle as a write of 16'hBEEF → write rejected, value unchanged, state LOCKED next cycle.
- TIMEOUT=4 with timer enabled: OPEN entered at cycle n+1 with no writes → LOCKED at n+5. A write at n+3 → LOCKED at n+8 instead.
- Timer macro undefined: OPEN held for 1000 idle cycles → still OPEN. A key write of any value → LOCKED next cycle.

Source files
------------

// File: rtl/rggen_bit_field_rwlk.sv
// Multi-channel lockable read-write bit field with a two-key unlock sequencer.
// Optional auto-relock idle timer is compiled in with RGGEN_RWLK_TIMEOUT_EN.
module rggen_bit_field_rwlk #(
    parameter int                          WIDTH         = 8,
    parameter int                          CHANNELS      = 2,
    parameter logic [CHANNELS*WIDTH-1:0]   INITIAL_VALUE = '0,
    parameter logic [WIDTH-1:0]            KEY0          = WIDTH'(8'hA5),
    parameter logic [WIDTH-1:0]            KEY1          = WIDTH'(8'h5A),
    parameter int                          TIMEOUT       = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_bit_field_valid,
    input  logic [CHANNELS*WIDTH-1:0]   i_bit_field_read_mask,
    input  logic [CHANNELS*WIDTH-1:0]   i_bit_field_write_mask,
    input  logic [CHANNELS*WIDTH-1:0]   i_bit_field_write_data,
    output logic [CHANNELS*WIDTH-1:0]   o_bit_field_read_data,
    output logic [CHANNELS*WIDTH-1:0]   o_bit_field_value,
    input  logic                        i_key_valid,
    input  logic [WIDTH-1:0]            i_key_data,
    input  logic                        i_lock,
    output logic                        o_locked,
    output logic [1:0]                  o_state,
    output logic [CHANNELS*WIDTH-1:0]   o_value
);

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        ARMED  = 2'd1,
        OPEN   = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [CHANNELS*WIDTH-1:0]   value_q, value_d;
    logic                        writeAccept;
    logic                        timerExpired;
    logic                        unusedReadMask;

    // The read mask is part of the bus contract but has no effect on this field.
    assign unusedReadMask = ^i_bit_field_read_mask;

    // Writes qualify on the pre-edge state; a force-lock in the same cycle wins.
    assign writeAccept = i_bit_field_valid && (|i_bit_field_write_mask) &&
                         (state_q == OPEN) && !i_lock;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= LOCKED;
            value_q <= INITIAL_VALUE;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_lock) begin
            state_d = LOCKED;
        end else begin
            case (state_q)
                LOCKED: begin
                    if (i_key_valid && (i_key_data == KEY0)) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (i_key_valid) begin
                        if (i_key_data == KEY1) begin
                            state_d = OPEN;
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                end
                OPEN: begin
                    if (i_key_valid || timerExpired) begin
                        state_d = LOCKED;
                    end
                end
                default: state_d = LOCKED;
            endcase
        end
    end

    always_comb begin
        value_d = value_q;
        if (writeAccept) begin
            value_d = (i_bit_field_write_data & i_bit_field_write_mask) |
                      (value_q & ~i_bit_field_write_mask);
        end
    end

`ifdef RGGEN_RWLK_TIMEOUT_EN
    localparam int TIMER_WIDTH = $clog2(TIMEOUT + 1);

    logic [TIMER_WIDTH-1:0] timer_q, timer_d;

    // Reading 1 on an idle OPEN cycle means this is the last cycle of the window.
    assign timerExpired = (state_q == OPEN) && (timer_q == TIMER_WIDTH'(1)) && !writeAccept;

    always_comb begin
        timer_d = '0;
        if (state_d == OPEN) begin
            if ((state_q != OPEN) || writeAccept) begin
                timer_d = TIMER_WIDTH'(TIMEOUT);
            end else begin
                timer_d = timer_q - TIMER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    localparam int unusedTimeout = TIMEOUT;

    assign timerExpired = 1'b0;
`endif

    always_comb begin
        o_locked              = (state_q != OPEN);
        o_state               = state_q;
        o_value               = value_q;
        o_bit_field_value     = value_q;
        o_bit_field_read_data = value_q;
    end

endmodule

// File: tb/tb_rggen_bit_field_rwlk.sv
// Self-checking bench for rggen_bit_field_rwlk: a cycle model of the lock rules plus
// directed unlock/relock/write sequences with literal expectations.
module tb_rggen_bit_field_rwlk;

    localparam int W  = 8;
    localparam int C  = 2;
    localparam int N  = W * C;
    localparam int TO = 4;

    logic         clk;
    logic         rst;
    logic         bfValid;
    logic [N-1:0] bfReadMask;
    logic [N-1:0] bfWriteMask;
    logic [N-1:0] bfWriteData;
    logic [N-1:0] bfReadData;
    logic [N-1:0] bfValue;
    logic         keyValid;
    logic [W-1:0] keyData;
    logic         lockIn;
    logic         locked;
    logic [1:0]   state;
    logic [N-1:0] value;

    int testsRun  = 0;
    int testsFail = 0;

    // Behavioural model: state as 0/1/2, field contents, and idle OPEN cycles counted
    int           mState;
    logic [N-1:0] mValue;
    int           mIdleOpen;
    bit           modelReady = 0;

    rggen_bit_field_rwlk #(
        .WIDTH    (W),
        .CHANNELS (C),
        .TIMEOUT  (TO)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_bit_field_valid      (bfValid),
        .i_bit_field_read_mask  (bfReadMask),
        .i_bit_field_write_mask (bfWriteMask),
        .i_bit_field_write_data (bfWriteData),
        .o_bit_field_read_data  (bfReadData),
        .o_bit_field_value      (bfValue),
        .i_key_valid            (keyValid),
        .i_key_data             (keyData),
        .i_lock                 (lockIn),
        .o_locked               (locked),
        .o_state                (state),
        .o_value                (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model advances on each rising edge from the inputs held across it
    always @(posedge clk) begin
        int  nextState;
        bit  accepted;
        if (rst) begin
            mState     = 0;
            mValue     = '0;
            mIdleOpen  = 0;
            modelReady = 1;
        end else if (modelReady) begin
            accepted  = bfValid && (bfWriteMask != '0) && (mState == 2) && !lockIn;
            nextState = mState;
            if (lockIn) nextState = 0;
            else if (mState == 0 && keyValid && keyData == 8'hA5) nextState = 1;
            else if (mState == 1 && keyValid) nextState = (keyData == 8'h5A) ? 2 : 0;
            else if (mState == 2 && keyValid) nextState = 0;
            if (accepted) begin
                mValue    = (bfWriteData & bfWriteMask) | (mValue & ~bfWriteMask);
                mIdleOpen = 0;
            end else if (mState == 2) begin
                mIdleOpen = mIdleOpen + 1;
`ifdef RGGEN_RWLK_TIMEOUT_EN
                if (mIdleOpen >= TO) nextState = 0;
`endif
            end
            if (nextState != 2) mIdleOpen = 0;
            mState = nextState;
        end
    end

    // Compare every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (modelReady && !rst) begin
            testsRun++;
            if (state !== 2'(mState) || locked !== (mState != 2) ||
                value !== mValue || bfValue !== mValue || bfReadData !== mValue) begin
                testsFail++;
                $display("[TB] FAIL model t=%0t: state=%0d locked=%0b value=%h bfv=%h rd=%h, required state=%0d locked=%0b value=%h",
                         $time, state, locked, value, bfValue, bfReadData,
                         mState, (mState != 2), mValue);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic v, input logic [N-1:0] m,
                                 input logic [N-1:0] d, input logic kv,
                                 input logic [W-1:0] k, input logic l);
        rst         = r;
        bfValid     = v;
        bfWriteMask = m;
        bfWriteData = d;
        keyValid    = kv;
        keyData     = k;
        lockIn      = l;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bfValid     = 1'b0;
        bfWriteMask = '0;
        bfWriteData = '0;
        keyValid    = 1'b0;
        keyData     = '0;
        lockIn      = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic key(input logic [W-1:0] k);
        applyStimulus(0, 0, '0, '0, 1, k, 0);
    endtask

    task automatic write(input logic [N-1:0] m, input logic [N-1:0] d);
        applyStimulus(0, 1, m, d, 0, '0, 0);
    endtask

    task automatic checkOutput(input string name, input logic expLocked,
                               input logic [1:0] expState, input logic [N-1:0] expValue);
        testsRun++;
        if (locked !== expLocked || state !== expState || value !== expValue) begin
            testsFail++;
            $display("[TB] FAIL %s: locked=%0b state=%0d value=%h, required locked=%0b state=%0d value=%h",
                     name, locked, state, value, expLocked, expState, expValue);
        end
    endtask

    initial begin
        rst = 1'b1; bfValid = 0; bfReadMask = '1; bfWriteMask = '0; bfWriteData = '0;
        keyValid = 0; keyData = '0; lockIn = 0;
        applyStimulus(1, 0, '0, '0, 0, '0, 0);
        checkOutput("reset", 1, 0, 16'h0000);

        write(16'hFFFF, 16'hFFFF);
        checkOutput("locked_write", 1, 0, 16'h0000);

        key(8'hA5);
        checkOutput("armed", 1, 1, 16'h0000);
        key(8'h5A);
        checkOutput("unlocked", 0, 2, 16'h0000);
        write(16'h00FF, 16'h1234);
        checkOutput("masked_write", 0, 2, 16'h0034);

        applyStimulus(0, 1, 16'hFFFF, 16'hBEEF, 0, '0, 1);
        checkOutput("force_lock_write", 1, 0, 16'h0034);

        key(8'hA5);
        key(8'h00);
        checkOutput("wrong_key1", 1, 0, 16'h0034);
        key(8'h5A);
        checkOutput("key1_alone", 1, 0, 16'h0034);
        write(16'hFFFF, 16'hFFFF);
        checkOutput("relocked_write", 1, 0, 16'h0034);

        key(8'hA5); key(8'h5A);
        key(8'h77);
        checkOutput("explicit_relock", 1, 0, 16'h0034);

        key(8'hA5); key(8'h5A);
        applyStimulus(0, 1, 16'hFF00, 16'hAB00, 1, 8'h11, 0);
        checkOutput("key_plus_write", 1, 0, 16'hAB34);

        key(8'hA5);
        applyStimulus(1, 0, '0, '0, 0, '0, 0);
        checkOutput("reset_armed", 1, 0, 16'h0000);

        key(8'hA5); key(8'h5A);
        write(16'hFFFF, 16'h00C3);
        checkOutput("open_write", 0, 2, 16'h00C3);
        applyStimulus(1, 1, 16'hFFFF, 16'hFFFF, 0, '0, 0);
        checkOutput("reset_open_write", 1, 0, 16'h0000);

`ifdef RGGEN_RWLK_TIMEOUT_EN
        key(8'hA5); key(8'h5A);
        idle(3);
        checkOutput("timer_last_open", 0, 2, 16'h0000);
        idle(1);
        checkOutput("timer_expired", 1, 0, 16'h0000);

        key(8'hA5); key(8'h5A);
        idle(1);
        write(16'h00FF, 16'h0055);
        idle(3);
        checkOutput("timer_reloaded_open", 0, 2, 16'h0055);
        idle(1);
        checkOutput("timer_reloaded_expired", 1, 0, 16'h0055);
`else
        key(8'hA5); key(8'h5A);
        idle(1000);
        checkOutput("no_timer_open", 0, 2, 16'h0000);
        key(8'h3C);
        checkOutput("no_timer_relock", 1, 0, 16'h0000);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
